oc_led_arb: RTL and testbench
=============================

OC_LED_ARB -- requirements
Module: oc_led_arb

Interface
REQ-001 Parameters SHALL be:
- NumReq, 4, number of requesters; 1..16; index 0 is highest priority.
- HoldTicks, 8, minimum ownership time in tick pulses; 0..255.
- CtrlMask, 32'h00073f03, valid LED control bits ([1:0] mode, [13:8] brightness, [18:16] blinks).
REQ-002 Ports SHALL be:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  single-cycle timebase pulse (for example the LED step pulse).
- req  in  NumReq  request, level-sensitive, one bit per requester.
- reqCtrl  in  NumReq x 32  LED control word per requester.
- defaultCtrl  in  32  control word shown when no requester owns the LED.
- grant  out  NumReq  one-hot ownership indication, or all zero.
- ledCtrl  out  32  control word for one LED, registered.
- busy  out  1  high when state is not IDLE.

Function
REQ-003 The block SHALL implement three states: IDLE, HOLD and OWNED.
REQ-004 Winner SHALL be the lowest-indexed asserted req bit; all other requesters are losers in that cycle.
REQ-005 In IDLE with req==0, next-cycle outputs SHALL be ledCtrl=defaultCtrl&CtrlMask and grant=0.
REQ-006 In IDLE with req!=0, the block SHALL register owner=winner, grant=1<<winner and ledCtrl=reqCtrl[winner]&CtrlMask, giving 1-cycle latency from req to grant.
REQ-007 On that grant, the block SHALL load holdCnt=HoldTicks and go to HOLD; if HoldTicks==0 it SHALL go directly to OWNED.
REQ-008 A tick coincident with the grant cycle SHALL NOT be counted.
REQ-009 In HOLD, each tick SHALL decrement holdCnt; a tick with holdCnt==1 SHALL move the state to OWNED in the next cycle.
REQ-010 In HOLD, no preemption SHALL occur; higher-priority requests SHALL wait.
REQ-011 In HOLD, if the owner drops req, ledCtrl SHALL keep its last value and grant SHALL stay asserted until the hold expires.
REQ-012 In HOLD and OWNED, while req[owner]=1, ledCtrl SHALL track reqCtrl[owner]&CtrlMask with 1-cycle latency.
REQ-013 In OWNED, arbitration SHALL run every cycle:
- winner==owner: no change.
- winner!=owner (higher priority, or owner dropped while another is requesting): switch owner, grant, ledCtrl and reload holdCnt exactly as in REQ-006/007, with no idle cycle between owners.
- req==0: return to IDLE; the next cycle gives grant=0 and ledCtrl=defaultCtrl&CtrlMask.
REQ-014 A lower-priority request SHALL never preempt a requesting owner.
REQ-015 grant SHALL be one-hot or zero in every cycle, and ledCtrl SHALL always equal its source &CtrlMask.
REQ-016 holdCnt SHALL be 8 bits and SHALL never wrap below 0.
REQ-017 busy SHALL be registered and SHALL equal (state!=IDLE).
REQ-018 Changes on reqCtrl of non-owners SHALL NOT affect the outputs.

Reset
REQ-019 While reset=1 at a clock edge, the block SHALL set state=IDLE, holdCnt=0, owner=0, grant=0, ledCtrl=0 and busy=0.
REQ-020 A reset asserted mid-HOLD or mid-OWNED SHALL abort ownership at the next edge with no other side effect.
REQ-021 After reset deasserts, the first non-reset cycle SHALL evaluate as IDLE.
REQ-022 ledCtrl SHALL show defaultCtrl only from the cycle after the first IDLE evaluation.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Idle default: defaultCtrl=32'hFFFFFFFF, req=0 -> ledCtrl=32'h00073f03, grant=0, busy=0.
- Basic grant: req=4'b0100, reqCtrl[2]=32'h00002a02, HoldTicks=3 -> next cycle grant=4'b0100 and ledCtrl=32'h00002a02; busy=1 until req drops after the 3rd tick, then IDLE.
- Hold blocks preemption: owner 3 granted; req[0] rises after 1 tick -> grant stays 4'b1000 until the 3rd tick; the cycle after reaching OWNED, grant=4'b0001; ledCtrl switches the same cycle as grant.
- Owner drop during hold: owner 1 drops req after 1 tick while req[2]=1 -> grant[1] held until hold expiry, then grant=4'b0100 with a fresh 3-tick hold.
- HoldTicks=0 with tick coincident with grant: immediate OWNED; higher-priority request preempts on the following cycle.
- Reset mid-HOLD: reset pulse -> grant=0, ledCtrl=0, busy=0 at the next edge; ledCtrl=defaultCtrl&mask two cycles after reset deasserts.

Source files
------------

// File: rtl/oc_led_arb.sv
// Single-LED control arbiter: fixed-priority requesters share one LED control word,
// and a new owner keeps the LED for a minimum number of tick pulses before it can be preempted.
module oc_led_arb #(
  parameter int          NumReq    = 4,
  parameter int          HoldTicks = 8,
  parameter logic [31:0] CtrlMask  = 32'h00073f03
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [NumReq-1:0]      req,
  input  logic [NumReq-1:0][31:0] reqCtrl,
  input  logic [31:0]            defaultCtrl,
  output logic [NumReq-1:0]      grant,
  output logic [31:0]            ledCtrl,
  output logic                   busy
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [7:0] HoldLoad = 8'(HoldTicks);

  typedef enum logic [1:0] {IDLE, HOLD, OWNED} state_t;

  state_t          state;
  logic [7:0]      hold_cnt;
  logic [IdxW-1:0] owner;
  logic [IdxW-1:0] winner;
  logic            any_req;

  // Lowest asserted index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req[i]) winner = IdxW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      owner    <= '0;
      grant    <= '0;
      ledCtrl  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= winner;
            grant    <= NumReq'(1) << winner;
            ledCtrl  <= reqCtrl[winner] & CtrlMask;
            hold_cnt <= HoldLoad;
            state    <= (HoldTicks == 0) ? OWNED : HOLD;
            busy     <= 1'b1;
          end else begin
            grant   <= '0;
            ledCtrl <= defaultCtrl & CtrlMask;
            busy    <= 1'b0;
          end
        end
        HOLD: begin
          // A dropped owner keeps its grant and last word until the hold runs out.
          if (req[owner]) ledCtrl <= reqCtrl[owner] & CtrlMask;
          if (tick && hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
          if (tick && hold_cnt <= 8'd1) state <= OWNED;
          busy <= 1'b1;
        end
        OWNED: begin
          if (!any_req) begin
            state   <= IDLE;
            grant   <= '0;
            ledCtrl <= defaultCtrl & CtrlMask;
            busy    <= 1'b0;
          end else if (winner != owner) begin
            owner    <= winner;
            grant    <= NumReq'(1) << winner;
            ledCtrl  <= reqCtrl[winner] & CtrlMask;
            hold_cnt <= HoldLoad;
            state    <= (HoldTicks == 0) ? OWNED : HOLD;
            busy     <= 1'b1;
          end else begin
            ledCtrl <= reqCtrl[owner] & CtrlMask;
            busy    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oc_led_arb.sv
// Bench for oc_led_arb: two instances (hold of 3 ticks and hold of 0) share one input
// stream and are compared every cycle against an owner/remaining-ticks reference model.
module tb_oc_led_arb;
  localparam int N = 4;
  localparam logic [31:0] Mask = 32'h00073f03;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              tick  = 1'b0;
  logic [N-1:0]      req   = '0;
  logic [N-1:0][31:0] rc   = '0;
  logic [31:0]       def   = '0;

  logic [N-1:0] grant_a, grant_b;
  logic [31:0]  led_a, led_b;
  logic         busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  int          own_a = -1, hold_a = 0, own_b = -1, hold_b = 0;
  logic [31:0] mled_a = '0, mled_b = '0;

  always #5 clock = ~clock;

  oc_led_arb #(.NumReq(N), .HoldTicks(3), .CtrlMask(Mask)) dut_a (
    .clock(clock), .reset(reset), .tick(tick), .req(req), .reqCtrl(rc),
    .defaultCtrl(def), .grant(grant_a), .ledCtrl(led_a), .busy(busy_a)
  );

  oc_led_arb #(.NumReq(N), .HoldTicks(0), .CtrlMask(Mask)) dut_b (
    .clock(clock), .reset(reset), .tick(tick), .req(req), .reqCtrl(rc),
    .defaultCtrl(def), .grant(grant_b), .ledCtrl(led_b), .busy(busy_b)
  );

  // Reference: owner index (-1 = nobody) plus ticks still to wait before preemption is allowed.
  task automatic model(input int hold_param, inout int own, inout int hold, inout logic [31:0] led);
    int w;
    w = -1;
    for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
    if (reset) begin
      own = -1; hold = 0; led = '0;
    end else if (own < 0) begin
      if (w < 0) led = def & Mask;
      else begin own = w; hold = hold_param; led = rc[w] & Mask; end
    end else if (hold > 0) begin
      if (tick) hold--;
      if (req[own]) led = rc[own] & Mask;
    end else if (w < 0) begin
      own = -1; led = def & Mask;
    end else if (w != own) begin
      own = w; hold = hold_param; led = rc[w] & Mask;
    end else begin
      led = rc[own] & Mask;
    end
  endtask

  function automatic logic [N-1:0] onehot(input int own);
    return (own < 0) ? '0 : N'(1) << own;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check32("grant_a", 32'(grant_a), 32'(onehot(own_a)));
    check32("led_a",   led_a,        mled_a);
    check32("busy_a",  32'(busy_a),  32'(own_a >= 0));
    check32("grant_b", 32'(grant_b), 32'(onehot(own_b)));
    check32("led_b",   led_b,        mled_b);
    check32("busy_b",  32'(busy_b),  32'(own_b >= 0));
  endtask

  task automatic apply_stimulus(input logic rst, input logic tk, input logic [N-1:0] r);
    reset = rst; tick = tk; req = r;
    @(posedge clock);
    model(3, own_a, hold_a, mled_a);
    model(0, own_b, hold_b, mled_b);
    #1;
    check_output();
  endtask

  initial begin
    // reset state
    apply_stimulus(1, 0, 4'b0000);
    apply_stimulus(1, 1, 4'b1111);
    check32("reset_led", led_a, 32'h0);

    // idle default
    def = 32'hFFFFFFFF;
    apply_stimulus(0, 0, 4'b0000);
    check32("idle_led", led_a, 32'h00073f03);
    check32("idle_grant", 32'(grant_a), 32'h0);

    // basic grant with 3-tick hold, then release
    rc[2] = 32'h00002a02;
    apply_stimulus(0, 0, 4'b0100);
    check32("basic_grant", 32'(grant_a), 32'h4);
    check32("basic_led", led_a, 32'h00002a02);
    apply_stimulus(0, 1, 4'b0100);
    apply_stimulus(0, 1, 4'b0100);
    apply_stimulus(0, 0, 4'b0100);
    apply_stimulus(0, 1, 4'b0100);
    check32("basic_busy", 32'(busy_a), 32'h1);
    apply_stimulus(0, 0, 4'b0000);
    check32("basic_idle_busy", 32'(busy_a), 32'h0);
    apply_stimulus(0, 0, 4'b0000);

    // hold blocks preemption
    rc[3] = 32'hDEAD8F81; rc[0] = 32'h00051203;
    apply_stimulus(0, 0, 4'b1000);
    apply_stimulus(0, 1, 4'b1000);
    apply_stimulus(0, 0, 4'b1001);
    check32("hold_noprempt", 32'(grant_a), 32'h8);
    apply_stimulus(0, 1, 4'b1001);
    apply_stimulus(0, 1, 4'b1001);
    check32("hold_expire_grant", 32'(grant_a), 32'h8);
    apply_stimulus(0, 0, 4'b1001);
    check32("preempt_grant", 32'(grant_a), 32'h1);
    check32("preempt_led", led_a, 32'h00051203);

    // owner drop during hold
    apply_stimulus(1, 0, 4'b0000);
    rc[1] = 32'h00013c01;
    apply_stimulus(0, 0, 4'b0010);
    apply_stimulus(0, 1, 4'b0110);
    rc[1] = 32'h00000000;
    apply_stimulus(0, 0, 4'b0100);
    check32("drop_grant_held", 32'(grant_a), 32'h2);
    check32("drop_led_held", led_a, 32'h00013c01);
    apply_stimulus(0, 1, 4'b0100);
    apply_stimulus(0, 1, 4'b0100);
    apply_stimulus(0, 0, 4'b0100);
    check32("drop_new_owner", 32'(grant_a), 32'h4);
    apply_stimulus(0, 1, 4'b0101);
    apply_stimulus(0, 1, 4'b0101);
    check32("drop_fresh_hold", 32'(grant_a), 32'h4);

    // zero hold with a coincident tick
    apply_stimulus(1, 0, 4'b0000);
    apply_stimulus(0, 1, 4'b0100);
    check32("zero_grant", 32'(grant_b), 32'h4);
    apply_stimulus(0, 0, 4'b0101);
    check32("zero_preempt", 32'(grant_b), 32'h1);

    // reset mid-hold
    apply_stimulus(1, 0, 4'b0000);
    def = 32'h12345678;
    apply_stimulus(0, 0, 4'b0010);
    apply_stimulus(0, 1, 4'b0010);
    apply_stimulus(1, 0, 4'b0010);
    check32("rst_grant", 32'(grant_a), 32'h0);
    check32("rst_led", led_a, 32'h0);
    check32("rst_busy", 32'(busy_a), 32'h0);
    apply_stimulus(0, 0, 4'b0000);
    check32("rst_default", led_a, 32'h00041600);

    // randomized traffic with sticky request patterns
    for (int n = 0; n < 500; n++) begin
      logic [N-1:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) if ($urandom_range(0, 2) == 0) rc[i] = $urandom;
      if ($urandom_range(0, 7) == 0) def = $urandom;
      apply_stimulus($urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
